// File: rtl/cpu_mem_if.sv
// Word-wide req/ack data bus between the memory stage and data memory.
interface cpu_mem_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    modport master (
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack
    );
endinterface

// File: rtl/cpu_mem.sv
// Memory-access pipeline stage: issues word loads/stores on a req/ack bus, stalls upstream
// until completion or timeout, and registers the write-back value and rf write controls.
module cpu_mem #(
    parameter int unsigned Timeout = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_c_rfw_i,
    input  logic [1:0]       ex_c_wbsource_i,
    input  logic             ex_c_drw_i,
    input  logic [31:0]      ex_alu_r_i,
    input  logic [31:0]      ex_rfb_i,
    input  logic [4:0]       ex_rf_waddr_i,
    input  logic [31:0]      ex_jalra_i,
    output logic             stall_o,
    cpu_mem_if.master        dbus,
    output logic             p_c_rfw_o,
    output logic [4:0]       p_rf_waddr_o,
    output logic [31:0]      p_wb_data_o,
    output logic             bus_err_o
);

    localparam logic [7:0] LastCnt = 8'(Timeout - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        d_req_q;
    logic        d_we_q;
    logic [31:0] d_addr_q;
    logic [31:0] d_wdata_q;
    logic        p_c_rfw_q;
    logic [4:0]  p_rf_waddr_q;
    logic [31:0] p_wb_data_q;
    logic        bus_err_q;

    logic memop;
    logic last_cycle;

    assign memop      = ex_c_drw_i | (ex_c_wbsource_i == 2'd1);
    assign last_cycle = (cnt_q == LastCnt);

    // Upstream is released on the ack edge, or on the timeout edge with no ack.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            StIdle:  stall_o = memop;
            StBusy:  stall_o = ~dbus.d_ack & ~last_cycle;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            d_req_q      <= 1'b0;
            d_we_q       <= 1'b0;
            d_addr_q     <= '0;
            d_wdata_q    <= '0;
            p_c_rfw_q    <= 1'b0;
            p_rf_waddr_q <= '0;
            p_wb_data_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (memop) begin
                        state_q   <= StBusy;
                        d_req_q   <= 1'b1;
                        d_we_q    <= ex_c_drw_i;
                        d_addr_q  <= {ex_alu_r_i[31:2], 2'b00};
                        d_wdata_q <= ex_rfb_i;
                        p_c_rfw_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        p_c_rfw_q    <= ex_c_rfw_i;
                        p_rf_waddr_q <= ex_rf_waddr_i;
                        p_wb_data_q  <= (ex_c_wbsource_i == 2'd2) ? ex_jalra_i : ex_alu_r_i;
                    end
                end
                StBusy: begin
                    if (dbus.d_ack) begin
                        state_q      <= StIdle;
                        d_req_q      <= 1'b0;
                        d_we_q       <= 1'b0;
                        p_c_rfw_q    <= ex_c_rfw_i & ~ex_c_drw_i;
                        p_rf_waddr_q <= ex_rf_waddr_i;
                        p_wb_data_q  <= ex_c_drw_i ? ex_alu_r_i : dbus.d_rdata;
                    end else if (last_cycle) begin
                        state_q      <= StIdle;
                        d_req_q      <= 1'b0;
                        d_we_q       <= 1'b0;
                        bus_err_q    <= 1'b1;
                        p_c_rfw_q    <= ex_c_rfw_i & ~ex_c_drw_i;
                        p_rf_waddr_q <= ex_rf_waddr_i;
                        p_wb_data_q  <= ex_c_drw_i ? ex_alu_r_i : 32'h0;
                    end else begin
                        cnt_q     <= cnt_q + 8'd1;
                        p_c_rfw_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dbus.d_req    = d_req_q;
    assign dbus.d_we     = d_we_q;
    assign dbus.d_addr   = d_addr_q;
    assign dbus.d_wdata  = d_wdata_q;
    assign p_c_rfw_o     = p_c_rfw_q;
    assign p_rf_waddr_o  = p_rf_waddr_q;
    assign p_wb_data_o   = p_wb_data_q;
    assign bus_err_o     = bus_err_q;

endmodule
